// File: rtl/mem_mport.sv
// Multi-read-port, single bit-masked write port synchronous memory with a
// post-reset clear sequencer and selectable write-first/read-first collisions.
module mem_mport #(
    parameter int WORD_SIZE      = 16,
    parameter int ADDR_SIZE      = 8,
    parameter int WORD_COUNT     = 2**ADDR_SIZE,
    parameter int READ_PORTS     = 2,
    parameter bit WRITE_FIRST    = 1'b1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                            clk,
    input  logic                            reset,
    output logic                            busy,
    input  logic [READ_PORTS-1:0]           r_en,
    input  logic [READ_PORTS*ADDR_SIZE-1:0] r_addr,
    output logic [READ_PORTS*WORD_SIZE-1:0] r_data,
    output logic [READ_PORTS-1:0]           r_valid,
    input  logic                            w_en,
    input  logic [ADDR_SIZE-1:0]            w_addr,
    input  logic [WORD_SIZE-1:0]            w_data,
    input  logic [WORD_SIZE-1:0]            w_mask
);

    typedef enum logic {S_CLEAR, S_READY} state_t;

    localparam logic [ADDR_SIZE-1:0] CLR_LAST = ADDR_SIZE'(WORD_COUNT - 1);

    state_t               state, state_next;
    logic [ADDR_SIZE-1:0] clr_addr;
    logic                 clr_last;
    logic                 ready;
    logic                 w_hit;
    logic [WORD_SIZE-1:0] w_word;
    logic [WORD_SIZE-1:0] rd_word [READ_PORTS];
    logic [WORD_SIZE-1:0] mem [WORD_COUNT];

    // Extra top bit so the compare also works when WORD_COUNT == 2**ADDR_SIZE.
    function automatic logic in_range(input logic [ADDR_SIZE-1:0] a);
        return {1'b0, a} < (ADDR_SIZE+1)'(WORD_COUNT);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state <= CLEAR_ON_RESET ? S_CLEAR : S_READY;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        clr_last   = (clr_addr == CLR_LAST);
        busy       = 1'b0;
        case (state)
            S_CLEAR: begin
                busy = 1'b1;
                if (clr_last) state_next = S_READY;
            end
            S_READY: state_next = S_READY;
            default: state_next = S_READY;
        endcase
    end

    assign ready  = (state == S_READY);
    assign w_hit  = ready & w_en & in_range(w_addr);
    assign w_word = w_hit ? ((mem[w_addr] & ~w_mask) | (w_data & w_mask)) : '0;

    always_comb begin
        for (int i = 0; i < READ_PORTS; i++) begin
            rd_word[i] = '0;
            if (in_range(r_addr[i*ADDR_SIZE +: ADDR_SIZE])) begin
                if (WRITE_FIRST && w_hit && (r_addr[i*ADDR_SIZE +: ADDR_SIZE] == w_addr))
                    rd_word[i] = w_word;
                else
                    rd_word[i] = mem[r_addr[i*ADDR_SIZE +: ADDR_SIZE]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)                 clr_addr <= '0;
        else if (state == S_CLEAR) clr_addr <= clr_last ? '0 : clr_addr + 1'b1;
    end

    // Array itself is not reset; the clear sequencer owns it while busy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == S_CLEAR) mem[clr_addr] <= '0;
            else if (w_hit)       mem[w_addr]   <= w_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data  <= '0;
            r_valid <= '0;
        end else begin
            for (int i = 0; i < READ_PORTS; i++) begin
                r_valid[i] <= ready & r_en[i];
                if (ready && r_en[i]) r_data[i*WORD_SIZE +: WORD_SIZE] <= rd_word[i];
            end
        end
    end

endmodule
